// File: rtl/copy_arbiter.sv
// Round-robin arbiter/sequencer sharing one copy_engine among NUM_REQ requesters.
// Issues start, waits for done or a cycle budget, acks the winner, and drains late dones.
module copy_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_src,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_dst,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            err,
  output logic [ADDR_W-1:0]             eng_src,
  output logic [ADDR_W-1:0]             eng_dst,
  output logic                          eng_start,
  input  logic                          eng_done,
  output logic                          busy,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] cur_id,
  output logic                          eng_hung
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;
  localparam logic [TMR_W-1:0] TMR_MAX  = '1;
  localparam logic [NUM_REQ-1:0] ONE    = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_t;

  state_t               state_q;
  logic [ID_W-1:0]      last_q;
  logic [ID_W-1:0]      cur_id_q;
  logic [TMR_W-1:0]     timer_q;
  logic                 err_flag_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic [NUM_REQ-1:0]   err_q;
  logic [ADDR_W-1:0]    eng_src_q;
  logic [ADDR_W-1:0]    eng_dst_q;
  logic                 eng_start_q;
  logic                 busy_q;
  logic                 eng_hung_q;

  logic [ID_W-1:0]      grant_id_d;
  logic                 grant_vld_d;

  // Scan from the farthest offset down so the closest pending requester after last_q wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_id_d  = '0;
    grant_vld_d = 1'b0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = int'(last_q) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[ID_W'(idx)]) begin
        grant_id_d  = ID_W'(idx);
        grant_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_q      <= ID_W'(NUM_REQ - 1);
      cur_id_q    <= '0;
      timer_q     <= '0;
      err_flag_q  <= 1'b0;
      ack_q       <= '0;
      err_q       <= '0;
      eng_src_q   <= '0;
      eng_dst_q   <= '0;
      eng_start_q <= 1'b0;
      busy_q      <= 1'b0;
      eng_hung_q  <= 1'b0;
    end else begin
      ack_q       <= '0;
      err_q       <= '0;
      eng_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_vld_d) begin
            state_q     <= S_ISSUE;
            cur_id_q    <= grant_id_d;
            eng_src_q   <= req_src[int'(grant_id_d)*ADDR_W +: ADDR_W];
            eng_dst_q   <= req_dst[int'(grant_id_d)*ADDR_W +: ADDR_W];
            eng_start_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
          timer_q <= '0;
        end
        S_WAIT: begin
          // A done in the same cycle as the budget expiring counts as success.
          if (eng_done) begin
            state_q    <= S_RESP;
            err_flag_q <= 1'b0;
            ack_q      <= ONE << cur_id_q;
          end else if ((TIMEOUT != 0) && (timer_q == TMR_LAST)) begin
            state_q    <= S_RESP;
            err_flag_q <= 1'b1;
            ack_q      <= ONE << cur_id_q;
            err_q      <= ONE << cur_id_q;
          end else if (timer_q != TMR_MAX) begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_RESP: begin
          last_q <= cur_id_q;
          if (err_flag_q) begin
            state_q    <= S_DRAIN;
            eng_hung_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_DRAIN: begin
          // The late done belongs to the failed transfer; swallow it without an ack.
          if (eng_done) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            eng_hung_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
          eng_hung_q <= 1'b0;
        end
      endcase
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign eng_src   = eng_src_q;
  assign eng_dst   = eng_dst_q;
  assign eng_start = eng_start_q;
  assign busy      = busy_q;
  assign cur_id    = cur_id_q;
  assign eng_hung  = eng_hung_q;

endmodule

// File: tb/tb_copy_arbiter.sv
// Scoreboard bench for copy_arbiter: expected starts/acks are queued by the stimulus
// and popped by a monitor whenever the DUT pulses eng_start or ack.
module tb_copy_arbiter;

  localparam int NR = 4;
  localparam int AW = 64;

  typedef struct {
    logic [1:0]    id;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
  } start_t;

  typedef struct {
    logic [NR-1:0] ack;
    logic [NR-1:0] err;
  } ack_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req;
  logic [NR*AW-1:0]  req_src;
  logic [NR*AW-1:0]  req_dst;
  logic [NR-1:0]     ack;
  logic [NR-1:0]     err;
  logic [AW-1:0]     eng_src;
  logic [AW-1:0]     eng_dst;
  logic              eng_start;
  logic              eng_done;
  logic              busy;
  logic [1:0]        cur_id;
  logic              eng_hung;

  int checks = 0;
  int errors = 0;
  start_t start_q[$];
  ack_t   ack_q[$];

  always #5 clk = ~clk;

  copy_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_src(req_src), .req_dst(req_dst),
    .ack(ack), .err(err), .eng_src(eng_src), .eng_dst(eng_dst),
    .eng_start(eng_start), .eng_done(eng_done), .busy(busy),
    .cur_id(cur_id), .eng_hung(eng_hung)
  );

  function automatic logic [AW-1:0] src_of(input int i);
    return 64'h1000 + 64'h10 * i;
  endfunction

  function automatic logic [AW-1:0] dst_of(input int i);
    return 64'h2000 + 64'h10 * i;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  task automatic monitor();
    start_t s;
    ack_t   a;
    forever begin
      @(negedge clk);
      if (eng_start === 1'b1) begin
        if (start_q.size() == 0) fail("unexpected_start");
        else begin
          s = start_q.pop_front();
          chk("start_cur_id", 64'(cur_id), 64'(s.id));
          chk("start_src", eng_src, s.src);
          chk("start_dst", eng_dst, s.dst);
          chk("start_busy", 64'(busy), 64'd1);
        end
      end
      if (ack !== '0) begin
        if (ack_q.size() == 0) fail("unexpected_ack");
        else begin
          a = ack_q.pop_front();
          chk("ack_vec", 64'(ack), 64'(a.ack));
          chk("err_vec", 64'(err), 64'(a.err));
        end
      end else if (err !== '0) begin
        fail("err_without_ack");
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req      = '0;
    eng_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ack"}, 64'(ack), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_start"}, 64'(eng_start), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_hung"}, 64'(eng_hung), 64'd0);
    chk({tag, "_src"}, eng_src, 64'd0);
    chk({tag, "_dst"}, eng_dst, 64'd0);
    chk({tag, "_cur_id"}, 64'(cur_id), 64'd0);
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (eng_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("start_timeout");
  endtask

  task automatic push_xfer(input int id, input logic e);
    start_t s;
    ack_t   a;
    s.id  = 2'(id);
    s.src = src_of(id);
    s.dst = dst_of(id);
    a.ack = 4'b0001 << id;
    a.err = e ? (4'b0001 << id) : 4'b0000;
    start_q.push_back(s);
    ack_q.push_back(a);
  endtask

  // Engine responds with done in the lat-th cycle after start; ack must follow next cycle.
  task automatic run_xfer(input int lat, input logic [NR-1:0] drop);
    bit ok;
    wait_start(ok);
    if (!ok) return;
    repeat (lat) @(posedge clk);
    #1 eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    @(negedge clk);
    chk("ack_after_done", 64'(ack != '0), 64'd1);
    tick();
    req = req & ~drop;
  endtask

  task automatic xfer(input int id, input int lat, input logic [NR-1:0] drop);
    push_xfer(id, 1'b0);
    run_xfer(lat, drop);
  endtask

  initial begin
    bit ok;
    rst_n    = 1'b0;
    req      = '0;
    eng_done = 1'b0;
    for (int i = 0; i < NR; i++) begin
      req_src[i*AW +: AW] = src_of(i);
      req_dst[i*AW +: AW] = dst_of(i);
    end
    fork
      monitor();
    join_none

    // Reset state
    do_reset();
    @(negedge clk);
    check_idle_outputs("reset");

    // Single request, done three cycles after start
    tick();
    req = 4'b0001;
    xfer(0, 3, 4'b0001);
    @(negedge clk);
    chk("single_busy_fall", 64'(busy), 64'd0);

    // Two requesters held: alternate 1,3,1,3
    do_reset();
    req = 4'b1010;
    xfer(1, 2, 4'b0000);
    xfer(3, 2, 4'b0000);
    xfer(1, 2, 4'b0000);
    xfer(3, 2, 4'b1010);

    // All four held: strict rotation for eight transfers
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 8; k++) xfer(k % 4, 1 + (k % 3), (k == 7) ? 4'b1111 : 4'b0000);
    @(negedge clk);
    chk("fair_idle_busy", 64'(busy), 64'd0);

    // Timeout with a dead engine, then drain and grant the pending requester
    do_reset();
    req = 4'b0001;
    push_xfer(0, 1'b1);
    wait_start(ok);
    tick();
    req = 4'b0101;
    repeat (16) @(negedge clk);
    chk("timeout_not_early", 64'(ack), 64'd0);
    @(negedge clk);
    chk("timeout_ack", 64'(ack), 64'h1);
    chk("timeout_err", 64'(err), 64'h1);
    tick();
    req = 4'b0100;
    repeat (8) @(negedge clk);
    chk("drain_hung", 64'(eng_hung), 64'd1);
    chk("drain_busy", 64'(busy), 64'd1);
    chk("drain_no_ack", 64'(ack), 64'd0);
    push_xfer(2, 1'b0);
    tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    @(negedge clk);
    chk("drain_exit_hung", 64'(eng_hung), 64'd0);
    chk("drain_exit_busy", 64'(busy), 64'd0);
    run_xfer(2, 4'b0100);

    // Done on the sixteenth WAIT cycle still succeeds
    req = 4'b0001;
    xfer(0, 16, 4'b0001);
    @(negedge clk);
    chk("boundary_no_drain", 64'(eng_hung), 64'd0);
    chk("boundary_busy", 64'(busy), 64'd0);

    // Reset during WAIT, spurious done in IDLE, then requester 0 wins first
    req = 4'b0010;
    begin
      start_t s;
      s.id = 2'd1; s.src = src_of(1); s.dst = dst_of(1);
      start_q.push_back(s);
    end
    wait_start(ok);
    tick();
    tick();
    rst_n = 1'b0;
    req   = '0;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("midreset");
    rst_n = 1'b1;
    tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("spurious_busy", 64'(busy), 64'd0);
    chk("spurious_ack", 64'(ack), 64'd0);
    tick();
    req = 4'b1001;
    xfer(0, 2, 4'b0001);
    xfer(3, 1, 4'b1000);

    repeat (4) @(negedge clk);
    chk("start_q_empty", 64'(start_q.size()), 64'd0);
    chk("ack_q_empty", 64'(ack_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
